// File: rtl/sa_autosa_pdp_pkg.sv
// Shared types for the PDP split-width scheduler: state encoding, surface constants
// and the shadow configuration captured at operation start.
package sa_autosa_pdp_pkg;

    localparam int ATOM_C     = 8;
    localparam int SURF_W     = 10;
    localparam int ATOM_SHIFT = $clog2(ATOM_C);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_SEG_END = 3'd3,
        ST_DONE    = 3'd4
    } pdp_state_e;

    typedef struct packed {
        logic [7:0]  splitw;
        logic [9:0]  width_first;
        logic [9:0]  width_mid;
        logic [9:0]  width_last;
        logic [12:0] cube_width;
        logic [12:0] height;
        logic [12:0] channel;
    } pdp_cfg_t;

    // An unsplit operation uses the full cube width; otherwise the segment position picks it.
    function automatic logic [12:0] sel_seg_width(input pdp_cfg_t cfg, input logic [7:0] idx);
        logic [12:0] w;
        if (cfg.splitw == 8'd0) begin
            w = cfg.cube_width;
        end else if (idx == 8'd0) begin
            w = {3'b000, cfg.width_first};
        end else if (idx == cfg.splitw) begin
            w = {3'b000, cfg.width_last};
        end else begin
            w = {3'b000, cfg.width_mid};
        end
        return w;
    endfunction

endpackage

// File: rtl/sa_autosa_pdp_split_sched_if.sv
// Segment-control bundle between the split scheduler (master) and the pooling datapath (slave).
interface sa_autosa_pdp_split_sched_if;

    // dp2wdma handshake: a beat transfers on a cycle where valid and ready are both high;
    // valid must not depend on ready, and out_hold is ANDed into ready by the datapath.
    logic        pdp_dp2wdma_valid;
    logic        pdp_dp2wdma_ready;

    logic        seg_start;
    logic [12:0] seg_width;
    logic [7:0]  seg_idx;
    logic        seg_is_first;
    logic        seg_is_last;
    logic        out_hold;

    modport master (
        input  pdp_dp2wdma_valid,
        input  pdp_dp2wdma_ready,
        output seg_start,
        output seg_width,
        output seg_idx,
        output seg_is_first,
        output seg_is_last,
        output out_hold
    );

    modport slave (
        output pdp_dp2wdma_valid,
        output pdp_dp2wdma_ready,
        input  seg_start,
        input  seg_width,
        input  seg_idx,
        input  seg_is_first,
        input  seg_is_last,
        input  out_hold
    );

endinterface

// File: rtl/sa_autosa_pdp_beat_cnt.sv
// Nested width/height/surface beat counters; terminal flags the beat that closes a segment.
module sa_autosa_pdp_beat_cnt
    import sa_autosa_pdp_pkg::*;
(
    input  logic              autosa_core_clk,
    input  logic              autosa_core_rst,
    input  logic              clear,
    input  logic              beat,
    input  logic [12:0]       w_lim,
    input  logic [12:0]       h_lim,
    input  logic [SURF_W-1:0] s_lim,
    output logic              terminal
);

    logic [12:0]       w_cnt;
    logic [12:0]       h_cnt;
    logic [SURF_W-1:0] s_cnt;
    logic              w_hit;
    logic              h_hit;
    logic              s_hit;

    assign w_hit    = (w_cnt == w_lim);
    assign h_hit    = (h_cnt == h_lim);
    assign s_hit    = (s_cnt == s_lim);
    assign terminal = beat & w_hit & h_hit & s_hit;

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst || clear) begin
            w_cnt <= '0;
            h_cnt <= '0;
            s_cnt <= '0;
        end else if (beat) begin
            if (w_hit) begin
                w_cnt <= '0;
                if (h_hit) begin
                    h_cnt <= '0;
                    s_cnt <= s_hit ? '0 : s_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end else begin
                w_cnt <= w_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_autosa_pdp_split_sched.sv
// Sequences one PDP operation across its split-width segments, announcing each segment
// and counting accepted output beats to find segment and operation boundaries.
module sa_autosa_pdp_split_sched
    import sa_autosa_pdp_pkg::*;
(
    input  logic                         autosa_core_clk,
    input  logic                         autosa_core_rst,
    input  logic                         reg2dp_op_en,
    input  logic [7:0]                   pooling_splitw_num_cfg,
    input  logic [9:0]                   reg2dp_partial_width_out_first,
    input  logic [9:0]                   reg2dp_partial_width_out_mid,
    input  logic [9:0]                   reg2dp_partial_width_out_last,
    input  logic [12:0]                  reg2dp_cube_out_width,
    input  logic [12:0]                  reg2dp_cube_out_height,
    input  logic [12:0]                  reg2dp_cube_in_channel,
    sa_autosa_pdp_split_sched_if.master  dp,
    output logic                         busy,
    output logic                         dp2reg_done,
    output logic                         beat_err,
    output pdp_state_e                   fsm_state
);

    pdp_state_e        state;
    pdp_state_e        state_nxt;
    pdp_cfg_t          cfg;
    logic              op_en_d;
    logic [7:0]        seg_idx_q;
    logic              beat_err_q;
    logic              start;
    logic              beat_acc;
    logic              beat_run;
    logic              seg_term;
    logic              last_seg;
    logic              cnt_clear;
    logic              seg_start_c;
    logic              done_c;
    logic [12:0]       cur_width;
    logic [SURF_W-1:0] surf_max;

    assign start     = reg2dp_op_en & ~op_en_d;
    assign beat_acc  = dp.pdp_dp2wdma_valid & dp.pdp_dp2wdma_ready;
    assign beat_run  = beat_acc & (state == ST_RUN);
    assign cur_width = sel_seg_width(cfg, seg_idx_q);
    assign surf_max  = SURF_W'(cfg.channel >> ATOM_SHIFT);
    assign last_seg  = (seg_idx_q == cfg.splitw);

    sa_autosa_pdp_beat_cnt u_beat_cnt (
        .autosa_core_clk (autosa_core_clk),
        .autosa_core_rst (autosa_core_rst),
        .clear           (cnt_clear),
        .beat            (beat_run),
        .w_lim           (cur_width),
        .h_lim           (cfg.height),
        .s_lim           (surf_max),
        .terminal        (seg_term)
    );

    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_clear   = 1'b0;
        seg_start_c = 1'b0;
        done_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                seg_start_c = 1'b1;
                cnt_clear   = 1'b1;
                state_nxt   = ST_RUN;
            end
            ST_RUN: begin
                if (seg_term) state_nxt = last_seg ? ST_DONE : ST_SEG_END;
            end
            ST_SEG_END: begin
                state_nxt = ST_LOAD;
            end
            ST_DONE: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A start in IDLE wins over a stray beat in the same cycle: the new operation begins clean.
    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            op_en_d    <= 1'b0;
            cfg        <= '0;
            seg_idx_q  <= '0;
            beat_err_q <= 1'b0;
        end else begin
            op_en_d <= reg2dp_op_en;
            if (state == ST_IDLE && start) begin
                cfg.splitw      <= pooling_splitw_num_cfg;
                cfg.width_first <= reg2dp_partial_width_out_first;
                cfg.width_mid   <= reg2dp_partial_width_out_mid;
                cfg.width_last  <= reg2dp_partial_width_out_last;
                cfg.cube_width  <= reg2dp_cube_out_width;
                cfg.height      <= reg2dp_cube_out_height;
                cfg.channel     <= reg2dp_cube_in_channel;
                seg_idx_q       <= '0;
                beat_err_q      <= 1'b0;
            end else begin
                if (state == ST_SEG_END) seg_idx_q <= seg_idx_q + 1'b1;
                if (beat_acc && state != ST_RUN) beat_err_q <= 1'b1;
            end
        end
    end

    assign busy            = (state != ST_IDLE);
    assign dp2reg_done     = done_c;
    assign beat_err        = beat_err_q;
    assign fsm_state       = state;
    assign dp.seg_start    = seg_start_c;
    assign dp.seg_width    = cur_width;
    assign dp.seg_idx      = seg_idx_q;
    assign dp.seg_is_first = busy & (seg_idx_q == 8'd0);
    assign dp.seg_is_last  = busy & last_seg;
    assign dp.out_hold     = busy & (state != ST_RUN);

endmodule

// File: tb/tb_sa_autosa_pdp_split_sched.sv
// Scenario bench for the PDP split scheduler against a segment-level reference model.
module tb_sa_autosa_pdp_split_sched;
    import sa_autosa_pdp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_en = 1'b0;
    logic [7:0]  splitw = '0;
    logic [9:0]  wf = '0, wm = '0, wl = '0;
    logic [12:0] cw = '0, hh = '0, cc = '0;
    logic        busy, done, beat_err;
    pdp_state_e  fsm_state;

    int checks = 0;
    int errors = 0;

    // Expected segment announcements {idx, width, first, last} and beats per segment.
    logic [22:0] exp_q[$];
    int          beats_q[$];

    always #5 clk = ~clk;

    sa_autosa_pdp_split_sched_if ifc ();

    sa_autosa_pdp_split_sched dut (
        .autosa_core_clk                (clk),
        .autosa_core_rst                (rst),
        .reg2dp_op_en                   (op_en),
        .pooling_splitw_num_cfg         (splitw),
        .reg2dp_partial_width_out_first (wf),
        .reg2dp_partial_width_out_mid   (wm),
        .reg2dp_partial_width_out_last  (wl),
        .reg2dp_cube_out_width          (cw),
        .reg2dp_cube_out_height         (hh),
        .reg2dp_cube_in_channel         (cc),
        .dp                             (ifc),
        .busy                           (busy),
        .dp2reg_done                    (done),
        .beat_err                       (beat_err),
        .fsm_state                      (fsm_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int s, input int f, input int m, input int l,
                           input int w, input int h, input int c);
        splitw = 8'(s); wf = 10'(f); wm = 10'(m); wl = 10'(l);
        cw = 13'(w); hh = 13'(h); cc = 13'(c);
    endtask

    // Each segment transfers width*height*surfaces beats.
    task automatic build_model();
        int n, w, beats, surf;
        logic first, last;
        exp_q.delete();
        beats_q.delete();
        n    = int'(splitw) + 1;
        surf = int'(cc) / ATOM_C + 1;
        for (int i = 0; i < n; i++) begin
            if (splitw == 0)          w = int'(cw);
            else if (i == 0)          w = int'(wf);
            else if (i == n - 1)      w = int'(wl);
            else                      w = int'(wm);
            beats = (w + 1) * (int'(hh) + 1) * surf;
            first = (i == 0);
            last  = (i == n - 1);
            exp_q.push_back({8'(i), 13'(w), first, last});
            beats_q.push_back(beats);
        end
    endtask

    task automatic run_op(input bit skip_edge, input bit bp, input bit inject_err,
                          input bit inject_op_en, input bit scramble);
        int n, need, got, cyc;
        bit stray, acc;
        logic [22:0] exp;
        logic [24:0] act;
        build_model();
        ifc.pdp_dp2wdma_valid = 1'b0;
        ifc.pdp_dp2wdma_ready = 1'b0;
        if (!skip_edge) begin
            op_en = 1'b0;
            tick();
        end
        op_en = 1'b1;
        tick();
        n = exp_q.size();
        for (int s = 0; s < n; s++) begin
            exp  = exp_q.pop_front();
            need = beats_q.pop_front();
            act  = {ifc.seg_start, ifc.seg_idx, ifc.seg_width, ifc.seg_is_first,
                    ifc.seg_is_last, ifc.out_hold};
            checks++;
            if (act !== {1'b1, exp, 1'b1}) begin
                errors++;
                $display("FAIL seg_start seg %0d: got %h expected %h", s, act, {1'b1, exp, 1'b1});
            end
            if (scramble && s == 0)
                set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2),
                        $urandom_range(0, 23));
            tick();
            if (inject_op_en && s == 0) begin
                op_en = 1'b0;
                tick();
                op_en = 1'b1;
            end
            got = 0; cyc = 0; stray = 0;
            while (got < need && cyc < 4000) begin
                ifc.pdp_dp2wdma_valid = 1'b1;
                ifc.pdp_dp2wdma_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                acc = ifc.pdp_dp2wdma_valid & ifc.pdp_dp2wdma_ready;
                if (ifc.out_hold !== 1'b0 || ifc.seg_start !== 1'b0 || done !== 1'b0) stray = 1;
                tick();
                if (acc) got++;
                cyc++;
            end
            ifc.pdp_dp2wdma_valid = 1'b0;
            checks++;
            if (stray || got < need) begin
                errors++;
                $display("FAIL seg_run seg %0d: early_end=%0d beats got %0d required %0d", s, stray, got, need);
            end
            if (s == n - 1) begin
                checks++;
                if ({done, busy, ifc.out_hold} !== 3'b111) begin
                    errors++;
                    $display("FAIL done_pulse: done/busy/hold got %b required 111", {done, busy, ifc.out_hold});
                end
                tick();
                checks++;
                if ({done, busy, ifc.out_hold} !== 3'b000) begin
                    errors++;
                    $display("FAIL done_idle: done/busy/hold got %b required 000", {done, busy, ifc.out_hold});
                end
            end else begin
                checks++;
                if ({ifc.out_hold, ifc.seg_start, done} !== 3'b100) begin
                    errors++;
                    $display("FAIL seg_end seg %0d: hold/start/done got %b required 100", s, {ifc.out_hold, ifc.seg_start, done});
                end
                if (inject_err && s == 0) begin
                    ifc.pdp_dp2wdma_valid = 1'b1;
                    ifc.pdp_dp2wdma_ready = 1'b1;
                end
                tick();
                ifc.pdp_dp2wdma_valid = 1'b0;
                if (inject_err && s == 0) begin
                    checks++;
                    if (beat_err !== 1'b1) begin
                        errors++;
                        $display("FAIL beat_err_set: got %b required 1", beat_err);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, beat_err, ifc.seg_start, ifc.seg_idx, ifc.seg_width,
             ifc.seg_is_first, ifc.seg_is_last, ifc.out_hold} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b start=%b idx=%0d width=%0d", busy, done, beat_err, ifc.seg_start, ifc.seg_idx, ifc.seg_width);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy got %b required 0", busy);
        end
    endtask

    task automatic test_single_segment();
        set_cfg(0, 0, 0, 0, 3, 1, 15);
        run_op(0, 0, 0, 0, 0);
    endtask

    task automatic test_three_segments();
        set_cfg(2, 1, 2, 0, 9, 0, 7);
        run_op(0, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        set_cfg(2, 1, 2, 0, 9, 0, 7);
        run_op(0, 1, 0, 0, 0);
    endtask

    task automatic test_error_restart();
        set_cfg(2, 1, 2, 0, 9, 0, 7);
        run_op(0, 0, 1, 1, 0);
        tick();
        tick();
        checks++;
        if ({busy, beat_err} !== 2'b01) begin
            errors++;
            $display("FAIL err_sticky_idle: busy/err got %b required 01", {busy, beat_err});
        end
        set_cfg(1, 2, 0, 1, 0, 1, 9);
        run_op(0, 0, 0, 0, 0);
        checks++;
        if (beat_err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b required 0", beat_err);
        end
    endtask

    task automatic test_reset_mid_run();
        set_cfg(0, 0, 0, 0, 3, 1, 15);
        op_en = 1'b0;
        tick();
        op_en = 1'b1;
        tick();
        tick();
        ifc.pdp_dp2wdma_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ifc.pdp_dp2wdma_valid = 1'b1;
            tick();
        end
        ifc.pdp_dp2wdma_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, beat_err, ifc.seg_start, ifc.seg_idx, ifc.seg_width,
             ifc.seg_is_first, ifc.seg_is_last, ifc.out_hold} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b start=%b idx=%0d width=%0d hold=%b", busy, done, ifc.seg_start, ifc.seg_idx, ifc.seg_width, ifc.out_hold);
        end
        run_op(1, 0, 0, 0, 0);
    endtask

    task automatic test_minimal();
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        run_op(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2),
                    $urandom_range(0, 23));
            run_op(0, 1, 0, 0, 1);
        end
    endtask

    initial begin
        ifc.pdp_dp2wdma_valid = 1'b0;
        ifc.pdp_dp2wdma_ready = 1'b0;
        test_reset();
        test_single_segment();
        test_three_segments();
        test_backpressure();
        test_error_restart();
        test_reset_mid_run();
        test_minimal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
